// File: rtl/rng_pkg.sv
// Shared definitions for the round-robin LFSR arbiter slice.
//   rng_state_e  : sequencer states
//   LFSR_TAPS    : feedback taps of the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   DEFAULT_SEED : reset seed and zero-seed substitute
//   idx_width()  : minimum 1-bit width for indices/counters
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STIR    = 2'd1,
        DELIVER = 2'd2
    } rng_state_e;

    localparam int unsigned LFSR_W       = 8;
    localparam logic [7:0]  LFSR_TAPS    = 8'b1011_1000;
    localparam logic [7:0]  DEFAULT_SEED = 8'hFF;

    // Width needed to index n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rng_if.sv
// Request/response/seed bundle between consumers and rng_arbiter.
//   master : consumer side (drives requests, rsp_ready and seed load)
//   slave  : arbiter side (drives grants, response and status)
interface rng_if #(
    parameter int unsigned NUM_REQ = 4
);
    import rng_pkg::*;

    localparam int unsigned ID_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [7:0]         rsp_data;
    logic [ID_W-1:0]    rsp_id;
    logic               seed_load;
    logic [7:0]         seed_data;
    logic               seed_ack;
    logic               busy;

    modport master (
        output req_i, rsp_ready, seed_load, seed_data,
        input  gnt_o, rsp_valid, rsp_data, rsp_id, seed_ack, busy
    );

    modport slave (
        input  req_i, rsp_ready, seed_load, seed_data,
        output gnt_o, rsp_valid, rsp_data, rsp_id, seed_ack, busy
    );

endinterface

// File: rtl/rng_lfsr_core.sv
// Free-running 8-bit Fibonacci LFSR with synchronous load.
//   clk, rst  : clock, synchronous active-high reset (loads SEED)
//   load      : replace state with load_data (SEED if load_data is zero)
//   load_data : new seed
//   lfsr_q    : current LFSR state
module rng_lfsr_core
    import rng_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic [7:0] lfsr_q
);

    // Zero would lock the LFSR, so it is swapped for SEED on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (load) begin
            lfsr_q <= (load_data == 8'h00) ? SEED : load_data;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among NUM_REQ requesters.
// A grant stirs the LFSR for STIR_CYCLES cycles, then one byte is
// delivered on a valid/ready channel tagged with the winner's id.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rng_if slave (req/gnt, rsp_*, seed_*, busy)
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned STIR_CYCLES = 2,
    parameter logic [7:0]  SEED        = DEFAULT_SEED
) (
    input  logic  clk,
    input  logic  rst,
    rng_if.slave  bus
);

    localparam int unsigned ID_W  = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = idx_width(STIR_CYCLES);

    rng_state_e       state_q;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       lfsr_q;
    logic             lfsr_load_c;
    logic [ID_W-1:0]  winner_c;
    logic             any_req_c;
    logic [ID_W-1:0]  scan_idx;

    // Reseeding is only honoured while idle.
    assign lfsr_load_c = (state_q == IDLE) && bus.seed_load;

    rng_lfsr_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (lfsr_load_c),
        .load_data (bus.seed_data),
        .lfsr_q    (lfsr_q)
    );

    // First set request scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        winner_c  = '0;
        any_req_c = 1'b0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!any_req_c && bus.req_i[scan_idx]) begin
                any_req_c = 1'b1;
                winner_c  = scan_idx;
            end
        end
    end

    // Sequencer: grant, stir, deliver; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            bus.gnt_o     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            bus.seed_ack  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.seed_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.seed_load) begin
                        bus.seed_ack <= 1'b1;
                    end
                    if (any_req_c) begin
                        bus.gnt_o  <= NUM_REQ'(1) << winner_c;
                        bus.rsp_id <= winner_c;
                        cnt        <= CNT_W'(STIR_CYCLES - 1);
                        state_q    <= STIR;
                        bus.busy   <= 1'b1;
                    end
                end
                STIR: begin
                    if (cnt == '0) begin
                        bus.rsp_data  <= lfsr_q;
                        bus.rsp_valid <= 1'b1;
                        state_q       <= DELIVER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DELIVER: begin
                    // Response and grant hold until the consumer takes it.
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.gnt_o     <= '0;
                        rr_ptr        <= ID_W'((32'(bus.rsp_id) + 32'd1) % NUM_REQ);
                        state_q       <= IDLE;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter: expected bytes/ids are queued when a
// request is driven and checked when the response handshake happens.
module tb_rng_arbiter;
    import rng_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned STIR    = 2;
    localparam logic [7:0]  SEED    = 8'hFF;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    rng_if #(.NUM_REQ(NUM_REQ)) bus ();

    rng_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .STIR_CYCLES (STIR),
        .SEED        (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    logic [7:0] m_lfsr;
    logic       m_load   = 1'b0;
    logic [7:0] m_seed   = 8'h00;

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        logic fb;
        fb = x[7] ^ x[5] ^ x[4] ^ x[3];
        return {x[6:0], fb};
    endfunction

    function automatic logic [7:0] adv_n(input logic [7:0] x, input int n);
        logic [7:0] v;
        v = x;
        for (int k = 0; k < n; k++) v = lfsr_step(v);
        return v;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] id);
        logic [3:0] v;
        v = 4'b0001;
        return v << id;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference LFSR; m_load is raised only for loads the bench knows occur in IDLE.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)         m_lfsr <= SEED;
        else if (m_load) m_lfsr <= (m_seed == 8'h00) ? SEED : m_seed;
        else             m_lfsr <= lfsr_step(m_lfsr);
    end

    // Scoreboard pop on every accepted response.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                check("rsp_id",   32'(bus.rsp_id),   32'(e.id));
                check("rsp_gnt",  32'(bus.gnt_o),    32'(onehot(e.id)));
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        check("rst_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_gnt",   32'(bus.gnt_o),     32'(0));
        check("rst_data",  32'(bus.rsp_data),  32'(0));
        check("rst_id",    32'(bus.rsp_id),    32'(0));
        check("rst_busy",  32'(bus.busy),      32'(0));
        check("rst_ack",   32'(bus.seed_ack),  32'(0));
        check("rst_lfsr",  32'(dut.lfsr_q),    32'(SEED));
        rst = 1'b0;
    endtask

    // One full transaction, entered and left at a negedge with the DUT idle.
    task automatic do_txn(input logic [3:0] req, input logic [1:0] exp_id,
                          input bit ld, input logic [7:0] sd, input bit drop,
                          input bit stir_seed, input int hold, output int rise_cyc);
        exp_t e;
        bus.req_i = req;
        e.id = exp_id;
        if (ld) begin
            bus.seed_load = 1'b1;
            bus.seed_data = sd;
            m_load = 1'b1;
            m_seed = sd;
            e.data = adv_n((sd == 8'h00) ? SEED : sd, STIR - 1);
        end else begin
            e.data = adv_n(m_lfsr, STIR);
        end
        sb.push_back(e);
        @(negedge clk);
        bus.seed_load = 1'b0;
        m_load = 1'b0;
        if (ld) check("seed_ack_grant", 32'(bus.seed_ack), 32'(1));
        check("gnt_onehot", 32'(bus.gnt_o), 32'(onehot(exp_id)));
        check("busy_stir",  32'(bus.busy),  32'(1));
        if (drop) bus.req_i = '0;
        if (stir_seed) begin
            bus.seed_load = 1'b1;
            bus.seed_data = 8'h5A;
        end
        for (int k = 0; k < int'(STIR); k++) begin
            check("valid_early", 32'(bus.rsp_valid), 32'(0));
            @(negedge clk);
            if (stir_seed && k == 0) begin
                bus.seed_load = 1'b0;
                check("stir_seed_ack",  32'(bus.seed_ack), 32'(0));
                check("stir_seed_lfsr", 32'(dut.lfsr_q),   32'(m_lfsr));
            end
        end
        check("valid_latency", 32'(bus.rsp_valid), 32'(1));
        check("data_rise",     32'(bus.rsp_data),  32'(e.data));
        rise_cyc = cyc;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 32'(1));
            check("hold_data",  32'(bus.rsp_data),  32'(e.data));
            check("hold_id",    32'(bus.rsp_id),    32'(exp_id));
            check("hold_gnt",   32'(bus.gnt_o),     32'(onehot(exp_id)));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_i     = '0;
        check("done_valid", 32'(bus.rsp_valid), 32'(0));
        check("done_gnt",   32'(bus.gnt_o),     32'(0));
        check("done_busy",  32'(bus.busy),      32'(0));
    endtask

    initial begin
        int r, r_prev;
        logic [1:0] fair_ids [5];
        fair_ids[0] = 2'd0; fair_ids[1] = 2'd1; fair_ids[2] = 2'd2;
        fair_ids[3] = 2'd3; fair_ids[4] = 2'd0;

        bus.req_i     = '0;
        bus.rsp_ready = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_data = 8'h00;
        @(negedge clk);
        do_reset(2);

        // First draw from the reset seed: FF -> FE -> FC.
        do_txn(4'b0001, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 0, r);
        check("first_expect_fc", 32'(adv_n(SEED, STIR)), 32'(8'hFC));

        // Fairness with all requesters active.
        do_reset(1);
        r_prev = 0;
        for (int t = 0; t < 5; t++) begin
            do_txn(4'b1111, fair_ids[t], 1'b0, 8'h00, 1'b0, 1'b0, 0, r);
            if (t > 0) check("rr_spacing", 32'(r - r_prev), 32'(STIR + 2));
            r_prev = r;
        end

        // Backpressure: ten cycles without rsp_ready.
        do_txn(4'b1111, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 10, r);

        // Request dropped after grant still completes.
        do_txn(4'b0100, 2'd2, 1'b0, 8'h00, 1'b1, 1'b0, 0, r);

        // Reseed in IDLE: 01 -> 02 -> 04, then zero seed substitutes FF.
        bus.seed_load = 1'b1; bus.seed_data = 8'h01;
        m_load = 1'b1; m_seed = 8'h01;
        @(negedge clk);
        bus.seed_load = 1'b0; m_load = 1'b0;
        check("seed_ack",    32'(bus.seed_ack), 32'(1));
        check("seed_lfsr0",  32'(dut.lfsr_q),   32'(8'h01));
        @(negedge clk);
        check("seed_ack_off", 32'(bus.seed_ack), 32'(0));
        check("seed_lfsr1",   32'(dut.lfsr_q),   32'(8'h02));
        @(negedge clk);
        check("seed_lfsr2",   32'(dut.lfsr_q),   32'(8'h04));
        bus.seed_load = 1'b1; bus.seed_data = 8'h00;
        m_load = 1'b1; m_seed = 8'h00;
        @(negedge clk);
        bus.seed_load = 1'b0; m_load = 1'b0;
        check("zero_seed_ack",  32'(bus.seed_ack), 32'(1));
        check("zero_seed_lfsr", 32'(dut.lfsr_q),   32'(8'hFF));
        check("model_sync",     32'(dut.lfsr_q),   32'(m_lfsr));

        // Seed applied on the same edge as a grant (rr_ptr=3 wraps to 0).
        do_txn(4'b0001, 2'd0, 1'b1, 8'h3C, 1'b0, 1'b0, 0, r);

        // Seed during STIR is ignored.
        do_txn(4'b0010, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 0, r);

        // Reset while a response is pending discards it.
        bus.req_i = 4'b0001;
        @(negedge clk);
        bus.req_i = '0;
        repeat (STIR) @(negedge clk);
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'(1));
        do_reset(1);

        // rr_ptr back to 0: requesters 1 and 2 pending -> 1 wins.
        do_txn(4'b0110, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 0, r);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 8-bit Fibonacci LFSR among NUM_REQ requesters. It stirs the LFSR for a fixed number of cycles between draws, then delivers one byte per grant over a valid/ready response channel tagged with the requester id. It also provides runtime reseeding with zero-seed protection. It sits between the LFSR datapath and the consumers, such as uo_out muxing logic or game/test engines.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
STIR_CYCLES, 2, LFSR advances between grant and capture (>=1)
SEED, 8'hFF, reset seed and substitute for a zero seed_data (must be nonzero)

Ports:
clk  in  1  clock; the only clock
rst  in  1  reset; synchronous, active-high
req_i  in  NUM_REQ  per-requester level request
gnt_o  out  NUM_REQ  one-hot grant, held from grant until response accepted
rsp_valid  out  1  response byte valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  random byte
rsp_id  out  $clog2(NUM_REQ)  index of granted requester
seed_load  in  1  request LFSR reseed
seed_data  in  8  new seed
seed_ack  out  1  one-cycle pulse: seed applied
busy  out  1  high in STIR or DELIVER

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset values: lfsr_q=SEED, state=IDLE, rr_ptr=0, gnt_o=0, rsp_valid=0, rsp_data=0, rsp_id=0, seed_ack=0, busy=0.
- LFSR (free-running, every cycle, all states):
  - lfsr_q <= {lfsr_q[6:0], lfsr_q[7]^lfsr_q[5]^lfsr_q[4]^lfsr_q[3]}.
  - On seed_load in IDLE it instead loads seed_data, or SEED if seed_data==0.
- Seeding:
  - seed_load is honoured only in IDLE; seed_ack pulses on the cycle after the load.
  - seed_load in STIR/DELIVER is ignored: no ack, no load. The source must retry.
- FSM states: IDLE, STIR, DELIVER.
- IDLE:
  - If any req_i bit is set, the winner is the first set bit scanning upward from rr_ptr, modulo NUM_REQ.
  - On that edge: gnt_o<=onehot(winner), rsp_id<=winner, cnt<=STIR_CYCLES-1, state<=STIR.
  - A seed_load on the same edge is also applied.
- STIR:
  - If cnt==0: rsp_data<=lfsr_q (pre-edge value), rsp_valid<=1, state<=DELIVER.
  - Otherwise cnt<=cnt-1.
- DELIVER:
  - rsp_valid, rsp_data, rsp_id and gnt_o are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, gnt_o<=0, rr_ptr<=(rsp_id+1) mod NUM_REQ, state<=IDLE.
- Latency: a request sampled at edge E produces rsp_valid high after edge E+STIR_CYCLES. Back-to-back grants are at minimum STIR_CYCLES+2 cycles apart.
- Request dropped after grant: the transaction still completes to the recorded rsp_id. Requests are never aborted.
- rsp_ready while rsp_valid=0 has no effect.
- Reset mid-operation: all state returns to reset values on the next edge. An in-flight response is discarded.
- The LFSR never reaches zero; the 255-state cycle is guaranteed by zero-seed substitution.
- busy = (state != IDLE).

Decomposition:
- Shared package rng_pkg holds:
  - the state enum (IDLE/STIR/DELIVER);
  - the LFSR tap constant (bits 7,5,4,3);
  - the default seed 8'hFF;
  - a width function for id sizing.
- Sub-module rng_lfsr_core holds the 8-bit LFSR with sync active-high rst, load and load_data. The arbiter FSM and round-robin logic stay in rng_arbiter.

Test Plan:
- Sequence: rst high 2 cycles, then req_i=4'b0001 held; lfsr goes FF->FE->FC -> rsp_valid after edge 3, rsp_data=8'hFC, rsp_id=0, gnt_o=4'b0001.
- Fairness: req_i=4'b1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. gnt_o is always one-hot, and each response is STIR_CYCLES+2 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles in DELIVER -> rsp_data/rsp_id/gnt_o stable, no new grant. rsp_ready=1 -> exactly one handshake, then IDLE.
- Seeding: in IDLE, seed_load with seed_data=8'h01 -> seed_ack next cycle, lfsr 01->02->04. seed_data=8'h00 -> lfsr loads FF. seed_load during STIR -> no ack, sequence unchanged.
- Mid-operation: req2 drops after grant -> response still delivered with rsp_id=2. rst asserted in DELIVER -> rsp_valid=0, gnt_o=0, lfsr=FF next edge.
